// File: rtl/wash_pkg.sv
// Shared state encoding, default phase durations and counter sizing for the washer controller.
// Defining WASH_EXTRA_RINSE_EN adds a second rinse (R2_FILL, R2_WASH, R2_DRAIN) before DRY.
package wash_pkg;

  localparam int DEF_FILL_CYC    = 64;
  localparam int DEF_WASH_CYC    = 512;
  localparam int DEF_RINSE_CYC   = 256;
  localparam int DEF_DRAIN_CYC   = 64;
  localparam int DEF_DRY_CYC     = 256;
  localparam int DEF_AGITATE_CYC = 16;
  localparam int CNT_MIN_W       = 10;

  typedef enum logic [3:0] {
    IDLE,
    C_FILL,
    C_WASH,
    C_DRAIN,
    R_FILL,
    R_WASH,
    R_DRAIN,
`ifdef WASH_EXTRA_RINSE_EN
    R2_FILL,
    R2_WASH,
    R2_DRAIN,
`endif
    DRY,
    DONE
  } state_e;

  function automatic int cnt_width(input int max_dur);
    int w;
    w = $clog2(max_dur);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = cnt_width(max_of(max_of(max_of(DEF_FILL_CYC, DEF_WASH_CYC),
                                                 max_of(DEF_RINSE_CYC, DEF_DRAIN_CYC)),
                                          max_of(DEF_DRY_CYC, DEF_AGITATE_CYC)));

  function automatic logic is_fill(input state_e s);
    return (s == C_FILL) || (s == R_FILL)
`ifdef WASH_EXTRA_RINSE_EN
           || (s == R2_FILL)
`endif
           ;
  endfunction

  function automatic logic is_wash(input state_e s);
    return (s == C_WASH) || (s == R_WASH)
`ifdef WASH_EXTRA_RINSE_EN
           || (s == R2_WASH)
`endif
           ;
  endfunction

  function automatic logic is_drain(input state_e s);
    return (s == C_DRAIN) || (s == R_DRAIN)
`ifdef WASH_EXTRA_RINSE_EN
           || (s == R2_DRAIN)
`endif
           ;
  endfunction

  function automatic logic is_clean(input state_e s);
    return (s == C_FILL) || (s == C_WASH) || (s == C_DRAIN);
  endfunction

  function automatic logic is_rinse(input state_e s);
    return (s == R_FILL) || (s == R_WASH) || (s == R_DRAIN)
`ifdef WASH_EXTRA_RINSE_EN
           || (s == R2_FILL) || (s == R2_WASH) || (s == R2_DRAIN)
`endif
           ;
  endfunction

endpackage

// File: rtl/wash_timer.sv
// Per-state cycle counter: cleared on state change, flags the last cycle of the current state.
module wash_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/wash_sequencer.sv
// Washer programme FSM: clean, rinse, dry, done, with registered valve/motor/panel outputs.
// Build option WASH_EXTRA_RINSE_EN inserts a second rinse cycle; ports are unchanged.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int FILL_CYC    = DEF_FILL_CYC,
  parameter int WASH_CYC    = DEF_WASH_CYC,
  parameter int RINSE_CYC   = DEF_RINSE_CYC,
  parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
  parameter int DRY_CYC     = DEF_DRY_CYC,
  parameter int AGITATE_CYC = DEF_AGITATE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic ctrl_fill,
  output logic ctrl_release,
  output logic ctrl_forward,
  output logic ctrl_reverse,
  output logic sig_clean,
  output logic sig_rinse,
  output logic sig_dry,
  output logic sig_done
);

  localparam int CW = cnt_width(max_of(max_of(max_of(FILL_CYC, WASH_CYC),
                                              max_of(RINSE_CYC, DRAIN_CYC)),
                                       max_of(DRY_CYC, AGITATE_CYC)));

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] agit_q, agit_d;
  logic [CW-1:0] last_d;
  logic          tc;
  logic          clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = C_FILL;
      C_FILL:     if (tc) state_d = C_WASH;
      C_WASH:     if (tc) state_d = C_DRAIN;
      C_DRAIN:    if (tc) state_d = R_FILL;
      R_FILL:     if (tc) state_d = R_WASH;
      R_WASH:     if (tc) state_d = R_DRAIN;
`ifdef WASH_EXTRA_RINSE_EN
      R_DRAIN:    if (tc) state_d = R2_FILL;
      R2_FILL:    if (tc) state_d = R2_WASH;
      R2_WASH:    if (tc) state_d = R2_DRAIN;
      R2_DRAIN:   if (tc) state_d = DRY;
`else
      R_DRAIN:    if (tc) state_d = DRY;
`endif
      DRY:        if (tc) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = '0;
    if (is_fill(state_q)) begin
      last_d = CW'(FILL_CYC - 1);
    end else if (state_q == C_WASH) begin
      last_d = CW'(WASH_CYC - 1);
    end else if (is_wash(state_q)) begin
      last_d = CW'(RINSE_CYC - 1);
    end else if (is_drain(state_q)) begin
      last_d = CW'(DRAIN_CYC - 1);
    end else if (state_q == DRY) begin
      last_d = CW'(DRY_CYC - 1);
    end
  end

  // Counter is held at zero while parked so every state starts its count from 0.
  assign clr = (state_d != state_q) || (state_q == IDLE) || (state_q == DONE);

  wash_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .last_i (last_d),
    .tc_o   (tc)
  );

  always_comb begin
    agit_d = '0;
    dir_d  = 1'b0;
    if ((state_d == state_q) && is_wash(state_q)) begin
      if (agit_q == CW'(AGITATE_CYC - 1)) begin
        dir_d = ~dir_q;
      end else begin
        agit_d = agit_q + 1'b1;
        dir_d  = dir_q;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      agit_q       <= '0;
      ctrl_fill    <= 1'b0;
      ctrl_release <= 1'b0;
      ctrl_forward <= 1'b0;
      ctrl_reverse <= 1'b0;
      sig_clean    <= 1'b0;
      sig_rinse    <= 1'b0;
      sig_dry      <= 1'b0;
      sig_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      agit_q       <= agit_d;
      ctrl_fill    <= is_fill(state_d);
      ctrl_release <= is_drain(state_d) || (state_d == DRY);
      ctrl_forward <= (is_wash(state_d) && !dir_d) || (state_d == DRY);
      ctrl_reverse <= is_wash(state_d) && dir_d;
      sig_clean    <= is_clean(state_d);
      sig_rinse    <= is_rinse(state_d);
      sig_dry      <= (state_d == DRY);
      sig_done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: scripted vector table, corner sequences and random run
// against a timeline model of the programme (elapsed cycles mapped onto a phase list).
module tb_wash_sequencer;

`ifdef WASH_EXTRA_RINSE_EN
  localparam int NSEG = 10;
`else
  localparam int NSEG = 7;
`endif
  localparam int AG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
  logic sig_clean, sig_rinse, sig_dry, sig_done;

  int checks = 0;
  int errors = 0;

  wash_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ctrl_fill    (ctrl_fill),
    .ctrl_release (ctrl_release),
    .ctrl_forward (ctrl_forward),
    .ctrl_reverse (ctrl_reverse),
    .sig_clean    (sig_clean),
    .sig_rinse    (sig_rinse),
    .sig_dry      (sig_dry),
    .sig_done     (sig_done)
  );

  always #5 clk = ~clk;

  // Programme as a list of segments: kind 0=fill 1=agitate 2=drain 3=dry; phase 0=clean 1=rinse 2=dry.
  int seg_len[NSEG];
  int seg_kind[NSEG];
  int seg_phase[NSEG];
  int total;

  int m_mode;  // 0 idle, 1 running, 2 done
  int m_t;     // cycles since the start sample

  typedef struct {
    bit         rst_n;
    bit         start;
    int         n;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] dut_out();
    return {ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse,
            sig_clean, sig_rinse, sig_dry, sig_done};
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    int acc, off;
    o = 8'h00;
    if (m_mode == 2) o = 8'b0000_0001;
    if (m_mode == 1) begin
      acc = 0;
      for (int k = 0; k < NSEG; k++) begin
        if (m_t >= acc && m_t < acc + seg_len[k]) begin
          off = m_t - acc;
          case (seg_kind[k])
            0: o[7] = 1'b1;
            1: begin
              o[5] = ((off / AG) % 2) == 0;
              o[4] = ((off / AG) % 2) == 1;
            end
            2: o[6] = 1'b1;
            default: begin
              o[6] = 1'b1;
              o[5] = 1'b1;
            end
          endcase
          o[3 - seg_phase[k]] = 1'b1;
        end
        acc += seg_len[k];
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (model t=%0d mode=%0d)", name, act, exp, m_t, m_mode);
    end
  endtask

  // One clock: inputs already set, model advances on the edge, outputs compared on the falling edge.
  task automatic step(input bit r, input bit s);
    rst_n = r;
    start = s;
    @(posedge clk);
    if (!r) begin
      m_mode = 0;
    end else if (m_mode != 1) begin
      if (s) begin
        m_mode = 1;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == total) m_mode = 2;
    end
    @(negedge clk);
    check("model", dut_out(), model_out());
    check("fwd_rev_excl", {7'd0, ctrl_forward & ctrl_reverse}, 8'd0);
    check("fill_rel_excl", {7'd0, ctrl_fill & ctrl_release}, 8'd0);
    check("phase_onehot", {7'd0, ($countones({sig_clean, sig_rinse, sig_dry, sig_done}) > 1)}, 8'd0);
  endtask

  initial begin
    int idx;
    int elapsed;
    bit seen;
    idx = 0;
    seg_len[idx] = 64;  seg_kind[idx] = 0; seg_phase[idx] = 0; idx++;
    seg_len[idx] = 512; seg_kind[idx] = 1; seg_phase[idx] = 0; idx++;
    seg_len[idx] = 64;  seg_kind[idx] = 2; seg_phase[idx] = 0; idx++;
    for (int r = 0; r < NSEG - 4; r += 3) begin
      seg_len[idx] = 64;  seg_kind[idx] = 0; seg_phase[idx] = 1; idx++;
      seg_len[idx] = 256; seg_kind[idx] = 1; seg_phase[idx] = 1; idx++;
      seg_len[idx] = 64;  seg_kind[idx] = 2; seg_phase[idx] = 1; idx++;
    end
    seg_len[idx] = 256; seg_kind[idx] = 3; seg_phase[idx] = 2;
    total = 0;
    for (int k = 0; k < NSEG; k++) total += seg_len[k];
    m_mode = 0;
    m_t = 0;

    // {rst_n, start, cycles, expected {fill,rel,fwd,rev,clean,rinse,dry,done} after the last cycle}
    tbl.push_back('{1'b0, 1'b0, 2,   8'b0000_0000});
    tbl.push_back('{1'b1, 1'b0, 100, 8'b0000_0000});
    tbl.push_back('{1'b1, 1'b1, 1,   8'b1000_1000});
    tbl.push_back('{1'b1, 1'b1, 1,   8'b1000_1000});
    tbl.push_back('{1'b1, 1'b0, 62,  8'b1000_1000});
    tbl.push_back('{1'b1, 1'b0, 1,   8'b0010_1000});
    tbl.push_back('{1'b1, 1'b0, 16,  8'b0001_1000});
    tbl.push_back('{1'b1, 1'b0, 16,  8'b0010_1000});
    tbl.push_back('{1'b1, 1'b0, 480, 8'b0100_1000});
    tbl.push_back('{1'b1, 1'b0, 63,  8'b0100_1000});
    tbl.push_back('{1'b1, 1'b0, 1,   8'b1000_0100});
    tbl.push_back('{1'b1, 1'b0, 80,  8'b0001_0100});
    tbl.push_back('{1'b1, 1'b0, total - 721, 8'b0110_0010});
    tbl.push_back('{1'b1, 1'b0, 1,   8'b0000_0001});
    tbl.push_back('{1'b1, 1'b0, 5,   8'b0000_0001});
    tbl.push_back('{1'b1, 1'b1, 1,   8'b1000_1000});
    tbl.push_back('{1'b0, 1'b0, 1,   8'b0000_0000});
    tbl.push_back('{1'b1, 1'b0, 10,  8'b0000_0000});

    @(negedge clk);
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].rst_n, tbl[i].start);
      check("vector", dut_out(), tbl[i].exp);
      $display("vec %0d: rst_n=%0b start=%0b cycles=%0d out=%b", i, tbl[i].rst_n, tbl[i].start,
               tbl[i].n, dut_out());
    end

    // Second start pulse 66 cycles in must not disturb the programme timing.
    step(1'b1, 1'b1);
    for (int c = 0; c < 65; c++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    elapsed = 66;
    seen = 1'b0;
    for (int c = 0; c < total + 50 && !seen; c++) begin
      step(1'b1, 1'b0);
      elapsed++;
      if (sig_done) seen = 1'b1;
    end
    check("done_latency", seen ? 8'(elapsed - total + 8) : 8'hFF, 8'd8);
    $display("seq restart-ignore: sig_done after %0d cycles (seen=%0b)", elapsed, seen);

    // Restart from DONE.
    step(1'b1, 1'b1);
    check("restart_from_done", dut_out(), 8'b1000_1000);
    $display("seq restart: out=%b", dut_out());

    // Reset during R_WASH (750 cycles into the programme).
    for (int c = 0; c < 750; c++) step(1'b1, 1'b0);
    check("in_r_wash", dut_out(), 8'b0010_0100);
    step(1'b0, 1'b0);
    check("midrun_reset", dut_out(), 8'b0000_0000);
    for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
    check("stay_idle", dut_out(), 8'b0000_0000);
    $display("seq midrun-reset: out=%b", dut_out());

    // Random start/reset traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      step(($urandom % 3000) != 0, ($urandom % 400) == 0);
    end
    $display("random phase done: model mode=%0d t=%0d", m_mode, m_t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
